mult_sequencer: RTL

Multi-cycle multiply sequencer for the pipeline's MULT/MULTU path. It accepts the start_mult/mult_sign decode from the control unit in EX and runs a radix-2 shift-add multiply over WIDTH cycles. It owns the HI/LO result registers. It raises a pipeline stall when an MFHI/MFLO or a second MULT reaches EX while a multiply is still in progress.

---
 rtl/mult_sequencer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mult_sequencer.sv
// rtl/mult_sequencer.sv - radix-2 shift-add MULT/MULTU sequencer owning HI/LO
module mult_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_mult,
  input  logic             mult_sign,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             mfhi_req,
  input  logic             mflo_req,
  input  logic             mult_abort,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [CW-1:0]        r_count;
  logic                 r_neg;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_done;

  logic                 w_accept;
  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic [2*WIDTH-1:0]   w_result;

  // Operand magnitudes; -2^(WIDTH-1) negates to itself, which reads correctly as unsigned.
  assign w_mag_a  = (mult_sign && op_a[WIDTH-1]) ? (~op_a + 1'b1) : op_a;
  assign w_mag_b  = (mult_sign && op_b[WIDTH-1]) ? (~op_b + 1'b1) : op_b;
  assign w_accept = (r_state == S_IDLE) && start_mult && !mult_abort;
  assign w_result = r_neg ? (~r_acc + 1'b1) : r_acc;

  assign busy  = (r_state == S_RUN) || (r_state == S_FIX);
  assign stall = busy && (mfhi_req || mflo_req || start_mult);
  assign hi    = r_hi;
  assign lo    = r_lo;
  assign done  = r_done;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; an abort in RUN or FIX drops straight back to IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next_state = S_RUN;
      end
      S_RUN: begin
        if (mult_abort)                  w_next_state = S_IDLE;
        else if (r_count == CW'(1))      w_next_state = S_FIX;
      end
      S_FIX: begin
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath: latch operands on accept, shift-add per RUN edge, sign-fix into HI/LO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
      r_neg    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
            r_mplier <= w_mag_b;
            r_neg    <= mult_sign & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            r_acc    <= '0;
            r_count  <= CW'(WIDTH);
          end
        end
        S_RUN: begin
          if (mult_abort) begin
            r_count <= '0;
          end else begin
            // r_mcand carries the running left shift of (WIDTH - count).
            if (r_mplier[0]) r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count - CW'(1);
          end
        end
        S_FIX: begin
          if (!mult_abort) begin
            r_hi   <= w_result[2*WIDTH-1:WIDTH];
            r_lo   <= w_result[WIDTH-1:0];
            r_done <= 1'b1;
          end
        end
        default: begin
          r_count <= '0;
        end
      endcase
    end
  end

endmodule
